prewitt_frame_sequencer: RTL and testbench

PREWITT_FRAME_SEQUENCER -- requirements
Module: prewitt_frame_sequencer

---
 rtl/prewitt_frame_sequencer.sv | 119 +++++++++++
 tb/tb_prewitt_frame_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prewitt_frame_sequencer.sv
// rtl/prewitt_frame_sequencer.sv - raster sequencer for a 3-line Prewitt window: input writes and centre issue
module prewitt_frame_sequencer #(
  parameter int ROWS = 242,
  parameter int COLS = 247,
  parameter int RW   = 8,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_wr_en,
  output logic [1:0]    lb_wr_sel,
  output logic [CW-1:0] lb_wr_addr,
  output logic          win_valid,
  input  logic          win_ready,
  output logic          win_border,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic [1:0]    win_sel
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW:0]   ROW_END  = (RW+1)'(ROWS);

  state_t        state;
  logic [RW-1:0] in_row, out_row;
  logic [CW-1:0] in_col, out_col;
  logic [1:0]    in_sel, out_sel;

  // One extra bit so out_row+1 / out_col+1 cannot wrap in the comparisons.
  logic [RW:0] in_row_x, out_row_p1;
  logic [CW:0] in_col_x, out_col_p1;
  logic        in_xfer, win_xfer, last_win, interior_ready;

  assign in_row_x   = {1'b0, in_row};
  assign out_row_p1 = {1'b0, out_row} + 1'b1;
  assign in_col_x   = {1'b0, in_col};
  assign out_col_p1 = {1'b0, out_col} + 1'b1;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  assign in_ready = busy && (in_row_x < ROW_END) && (in_row_x <= out_row_p1);
  assign lb_wr_en = in_valid && in_ready;

  assign win_border = (out_row == '0) || (out_row == ROW_LAST) ||
                      (out_col == '0) || (out_col == COL_LAST);
  // Interior centre needs its lower-right neighbour (out_row+1, out_col+1) already written.
  assign interior_ready = (in_row_x > out_row_p1) ||
                          ((in_row_x == out_row_p1) && (in_col_x > out_col_p1));
  assign win_valid = busy && (win_border || interior_ready);

  assign in_xfer  = in_valid && in_ready;
  assign win_xfer = win_valid && win_ready;
  assign last_win = (out_row == ROW_LAST) && (out_col == COL_LAST);

  assign lb_wr_sel  = in_sel;
  assign lb_wr_addr = in_col;
  assign win_row    = out_row;
  assign win_col    = out_col;
  assign win_sel    = out_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      in_row  <= '0;
      in_col  <= '0;
      in_sel  <= '0;
      out_row <= '0;
      out_col <= '0;
      out_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            in_row  <= '0;
            in_col  <= '0;
            in_sel  <= '0;
            out_row <= '0;
            out_col <= '0;
            out_sel <= '0;
          end
        end
        RUN: begin
          if (in_xfer) begin
            if (in_col == COL_LAST) begin
              in_col <= '0;
              in_row <= in_row + 1'b1;
              in_sel <= (in_sel == 2'd2) ? 2'd0 : in_sel + 2'd1;
            end else begin
              in_col <= in_col + 1'b1;
            end
          end
          if (win_xfer) begin
            if (last_win) state <= DONE;
            if (out_col == COL_LAST) begin
              out_col <= '0;
              out_row <= out_row + 1'b1;
              out_sel <= (out_sel == 2'd2) ? 2'd0 : out_sel + 2'd1;
            end else begin
              out_col <= out_col + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prewitt_frame_sequencer.sv
// tb/tb_prewitt_frame_sequencer.sv - directed and random-handshake bench for prewitt_frame_sequencer
module tb_prewitt_frame_sequencer;
  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int RW   = 8;
  localparam int CW   = 8;

  logic          clk, rst_n, start, busy, done, in_valid, in_ready;
  logic          lb_wr_en, win_valid, win_ready, win_border;
  logic [1:0]    lb_wr_sel, win_sel;
  logic [CW-1:0] lb_wr_addr, win_col;
  logic [RW-1:0] win_row;

  prewitt_frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .lb_wr_en(lb_wr_en),
    .lb_wr_sel(lb_wr_sel), .lb_wr_addr(lb_wr_addr), .win_valid(win_valid),
    .win_ready(win_ready), .win_border(win_border), .win_row(win_row),
    .win_col(win_col), .win_sel(win_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frames = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model driven only by observed handshakes; positions are pixel indices.
  int   m_in = 0, m_out = 0;
  int   mr, mc, mir;
  logic mbd, mir_ok, mwv, pv;
  logic [RW-1:0] pr;
  logic [CW-1:0] pc;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_in = 0; m_out = 0; pv = 1'b0;
    end else begin
      if (busy) begin
        mr  = m_out / COLS;
        mc  = m_out % COLS;
        mir = m_in / COLS;
        mbd = (mr == 0) || (mr == ROWS-1) || (mc == 0) || (mc == COLS-1);
        mir_ok = (m_in < ROWS*COLS) && (mir <= mr + 1);
        mwv = mbd || (m_in > (mr+1)*COLS + mc + 1);
        chk("mon_in_ready", 32'(in_ready), 32'(mir_ok));
        chk("mon_win_valid", 32'(win_valid), 32'(mwv));
        chk("mon_lb_wr_en", 32'(lb_wr_en), 32'(in_valid && mir_ok));
        chk("mon_lb_wr_sel", 32'(lb_wr_sel), mir % 3);
        chk("mon_lb_wr_addr", 32'(lb_wr_addr), m_in % COLS);
        chk("mon_win_row", 32'(win_row), mr);
        chk("mon_win_col", 32'(win_col), mc);
        chk("mon_win_border", 32'(win_border), 32'(mbd));
        chk("mon_win_sel", 32'(win_sel), 32'(win_row) % 3);
        if (pv) chk("mon_stall_hold", {15'd0, win_valid, win_row, win_col}, {15'd0, 1'b1, pr, pc});
        pv = win_valid && !win_ready;
        pr = win_row;
        pc = win_col;
        if (in_valid && in_ready) m_in++;
        if (win_valid && win_ready) m_out++;
      end else begin
        pv = 1'b0;
      end
      if (done) begin
        chk("mon_frame_inputs", m_in, ROWS*COLS);
        chk("mon_frame_windows", m_out, ROWS*COLS);
        frames++;
      end
      if (!busy) begin
        m_in = 0; m_out = 0;
      end
    end
  end

  typedef struct {
    int   cyc;
    logic iv, wr;
    logic ir, wv;
    int   row, col;
    logic bd;
    int   sel, addr;
  } vec_t;
  vec_t tbl[11];

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input logic rnd, output logic got);
    got = 1'b0;
    for (int k = 0; k < maxc && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      @(posedge clk); #1;
      if (rnd) begin
        in_valid  = 1'($urandom_range(0, 1));
        win_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  logic got;
  int   n;

  initial begin
    // {cycle, in_valid, win_ready, in_ready, win_valid, row, col, border, lb_wr_sel, lb_wr_addr}
    tbl[0]  = '{1,  1, 1, 1, 1, 0, 0, 1, 0, 0};
    tbl[1]  = '{6,  1, 1, 1, 1, 1, 0, 1, 1, 0};
    tbl[2]  = '{7,  1, 1, 1, 0, 1, 1, 0, 1, 1};
    tbl[3]  = '{13, 1, 1, 1, 0, 1, 1, 0, 2, 2};
    tbl[4]  = '{14, 1, 1, 1, 1, 1, 1, 0, 2, 3};
    tbl[5]  = '{16, 1, 1, 0, 1, 1, 3, 0, 0, 0};
    tbl[6]  = '{17, 1, 1, 0, 1, 1, 4, 1, 0, 0};
    tbl[7]  = '{19, 1, 1, 1, 0, 2, 1, 0, 0, 1};
    tbl[8]  = '{22, 1, 1, 1, 1, 2, 2, 0, 0, 4};
    tbl[9]  = '{23, 1, 1, 0, 1, 2, 3, 0, 1, 0};
    tbl[10] = '{29, 1, 1, 0, 1, 3, 4, 1, 1, 0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; in_valid = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_win_valid", 32'(win_valid), 0);
    chk("rst_lb_wr_en", 32'(lb_wr_en), 0);
    chk("rst_win_pos", {16'd0, win_row, win_col}, 0);
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("idle_win_valid", 32'(win_valid), 0);
    end

    // Free-running frame against hand-computed cycle table.
    @(posedge clk); #1 in_valid = 1'b1; win_ready = 1'b1;
    start_frame();
    for (int cyc = 1; cyc <= 31; cyc++) begin
      @(negedge clk);
      chk("free_busy", 32'(busy), 32'(cyc <= 29));
      chk("free_done", 32'(done), 32'(cyc == 30));
      for (int i = 0; i < 11; i++) begin
        if (tbl[i].cyc == cyc) begin
          chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].ir));
          chk("tbl_win_valid", 32'(win_valid), 32'(tbl[i].wv));
          chk("tbl_win_row", 32'(win_row), tbl[i].row);
          chk("tbl_win_col", 32'(win_col), tbl[i].col);
          chk("tbl_win_border", 32'(win_border), 32'(tbl[i].bd));
          chk("tbl_lb_wr_sel", 32'(lb_wr_sel), tbl[i].sel);
          chk("tbl_lb_wr_addr", 32'(lb_wr_addr), tbl[i].addr);
        end
      end
      @(posedge clk); #1 in_valid = tbl[0].iv; win_ready = tbl[0].wr;
    end

    // Output stall with a stray start mid-frame.
    win_ready = 1'b0; in_valid = 1'b1;
    start_frame();
    n = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (lb_wr_en) n++;
      if (cyc == 1 || cyc == 16 || cyc == 30)
        chk("stall_hold", {14'd0, win_valid, win_border, win_row, win_col}, {14'd0, 1'b1, 1'b1, 16'd0});
      @(posedge clk); #1 start = (cyc == 15);
    end
    chk("stall_accepted", n, 10);
    chk("stall_in_ready", 32'(in_ready), 0);
    win_ready = 1'b1;
    wait_done(200, 1'b0, got);
    chk("stall_frame_done", 32'(got), 1);

    // Three frames with random handshakes; the monitor carries the checking.
    for (int f = 0; f < 3; f++) begin
      start_frame();
      wait_done(600, 1'b1, got);
      chk("rand_frame_done", 32'(got), 1);
    end

    // Reset after seven pixels abandons the frame.
    in_valid = 1'b1; win_ready = 1'b0;
    start_frame();
    n = 0;
    for (int k = 0; k < 40 && n < 7; k++) begin
      @(negedge clk);
      if (lb_wr_en) n++;
      @(posedge clk); #1;
    end
    chk("mid_accepted", n, 7);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_in_ready", 32'(in_ready), 0);
    chk("mid_lb_wr_en", 32'(lb_wr_en), 0);
    chk("mid_win_valid", 32'(win_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_done", 32'(done), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1; win_ready = 1'b1;
    start_frame();
    @(negedge clk);
    chk("restart_wr_en", 32'(lb_wr_en), 1);
    chk("restart_wr_sel", 32'(lb_wr_sel), 0);
    chk("restart_wr_addr", 32'(lb_wr_addr), 0);
    chk("restart_win_pos", {16'd0, win_row, win_col}, 0);
    @(posedge clk); #1;
    wait_done(200, 1'b0, got);
    chk("restart_frame_done", 32'(got), 1);

    @(negedge clk);
    chk("frames_completed", frames, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
